// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - synchronous modulo-N up/down counter with run control
// Load overrides counting on its edge; stop beats start; busy/done/tc are flops fed from next-state logic.
module mod_n_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  // One extra bit so the clamp compare still works when MOD == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             count_en;
  logic             wrap;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tc_d         = 1'b0;
    load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;
    count_en     = (state_q == ST_RUN) && en && !stop && !load;
    wrap         = count_en && (up_dn ? (cnt_q == MAX_CNT) : (cnt_q == '0));

    if (load) begin
      cnt_d = load_clamped;
    end else if (count_en) begin
      if (wrap) begin
        cnt_d = up_dn ? '0 : MAX_CNT;
      end else begin
        cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
    tc_d = wrap;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (wrap && one_shot) state_d = ST_DONE;
        ST_DONE: if (start) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - table-driven scoreboard bench for mod_n_counter (WIDTH=4, MOD=10)
module tb_mod_n_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, start, stop, one_shot, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, busy, done;
    bit         seq_done = 1'b0;

    mod_n_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
        .one_shot(one_shot), .load(load), .load_val(load_val),
        .q(q), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         rst_n, en, up, start, stop, os, ld;
        logic [3:0] lv;
        logic [3:0] eq;
        bit         etc, eb, ed;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] eq;
        bit         etc, eb, ed;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    task automatic add(input string tag, input bit rst_n, en_v, up, st, sp, os, ld,
                       input logic [3:0] lv, input logic [3:0] eq,
                       input bit etc, eb, ed);
        vec_t v;
        v.tag = tag; v.rst_n = rst_n; v.en = en_v; v.up = up; v.start = st; v.stop = sp;
        v.os = os; v.ld = ld; v.lv = lv; v.eq = eq; v.etc = etc; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        if (!seq_done) begin
            n_miscompares++;
            $display("FAIL timeout: vector sequence did not complete, %0d vectors applied", n_applied);
            $finish;
        end
    end

    initial begin
        exp_t e;
        vec_t v;
        reset = 1'b0; en = 0; up_dn = 1; start = 0; stop = 0; one_shot = 0; load = 0; load_val = 0;

        add("reset0",       0, 0, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0);
        add("reset1",       0, 0, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0);
        add("post_reset",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fr_start",     1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++)
            add("fr_up",    1, 1, 1, 0, 0, 0, 0, 0, 4'(i), 0, 1, 0);
        add("fr_wrap",      1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add("fr_1",         1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        add("fr_2",         1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0);
        add("fr_stop",      1, 1, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        add("dn_load2",     1, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
        add("dn_start",     1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 1, 0);
        add("dn_1",         1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        add("dn_0",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add("dn_wrap9",     1, 1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0);
        add("dn_8",         1, 1, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0);
        add("dir_up9",      1, 1, 1, 0, 0, 0, 0, 0, 9, 0, 1, 0);
        add("dir_wrap0",    1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add("dn_stop",      1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add("os_load7",     1, 0, 1, 0, 0, 1, 1, 7, 7, 0, 0, 0);
        add("os_start",     1, 0, 1, 1, 0, 1, 0, 0, 7, 0, 1, 0);
        add("os_8",         1, 1, 1, 0, 0, 1, 0, 0, 8, 0, 1, 0);
        add("os_9",         1, 1, 1, 0, 0, 1, 0, 0, 9, 0, 1, 0);
        add("os_done",      1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        add("os_hold",      1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add("os_restart",   1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        add("os_stop",      1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add("ld_clamp13",   1, 0, 1, 0, 0, 0, 1, 13, 9, 0, 0, 0);
        add("ld_start",     1, 0, 1, 1, 0, 1, 0, 0, 9, 0, 1, 0);
        add("ld_on_wrap",   1, 1, 1, 0, 0, 1, 1, 4, 4, 0, 1, 0);
        add("ld_cnt5",      1, 1, 1, 0, 0, 1, 0, 0, 5, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add("en0_frozen", 1, 0, 1, 0, 0, 0, 0, 0, 5, 0, 1, 0);
        add("stop_at5",     1, 1, 1, 0, 1, 0, 0, 0, 5, 0, 0, 0);
        add("start_stop",   1, 1, 1, 1, 1, 0, 0, 0, 5, 0, 0, 0);
        add("rm_start",     1, 0, 1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
        add("rm_6",         1, 1, 1, 0, 0, 0, 0, 0, 6, 0, 1, 0);
        add("rm_reset",     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rm_idle",      1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rw_start",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add("rw_load9",     1, 0, 1, 0, 0, 0, 1, 9, 9, 0, 1, 0);
        add("rw_reset_tc",  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rw_after",     1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("ls_start",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add("ld_and_stop",  1, 1, 1, 0, 1, 0, 1, 3, 3, 0, 0, 0);
        add("ls_idle_hold", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add("dn_rs_start",  1, 0, 0, 1, 0, 1, 0, 0, 3, 0, 1, 0);
        add("dn_os_2",      1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
        add("dn_os_1",      1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
        add("dn_os_0",      1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add("dn_os_done",   1, 1, 0, 0, 0, 1, 0, 0, 9, 1, 0, 1);
        add("done_stop",    1, 0, 0, 0, 1, 0, 0, 0, 9, 0, 0, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            reset = v.rst_n; en = v.en; up_dn = v.up; start = v.start; stop = v.stop;
            one_shot = v.os; load = v.ld; load_val = v.lv;
            e.tag = v.tag; e.eq = v.eq; e.etc = v.etc; e.eb = v.eb; e.ed = v.ed;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_applied++;
            if (q !== e.eq || tc !== e.etc || busy !== e.eb || done !== e.ed) begin
                n_miscompares++;
                $display("FAIL %s (vec %0d): got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                         e.tag, i, q, tc, busy, done, e.eq, e.etc, e.eb, e.ed);
            end
            if (!v.rst_n && (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0)) begin
                n_miscompares++;
                $display("FAIL reset-state %s (vec %0d): got q=%0d tc=%b busy=%b done=%b, expected all zero",
                         v.tag, i, q, tc, busy, done);
            end
        end

        seq_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
